// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: registered fetch port plus byte-serial program loader.
// Define IMEM_PARITY_EN to store an even-parity bit per word and flag fetch_perr on mismatch.
module instruction_memory_loadable #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_misalign,
  output logic              fetch_perr,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);
  localparam int DEPTH = 2 ** ADDR_W;
  if (DATA_W != 32) begin : g_bad_cfg
    $error("instruction_memory_loadable: DATA_W must be 32");
  end
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   len;
  logic [1:0]        byte_idx;
  logic [23:0]       asm_q;
  logic [ADDR_W-1:0] raddr;
  logic              take, wr, fetch_ok, aligned, perr_next;
  logic [31:0]       wword;
  assign raddr    = fetch_addr[ADDR_W+1:2];
  assign take     = state == LOAD && ld_byte_valid;
  assign wr       = take && byte_idx == 2'd3;
  assign wword    = {asm_q, ld_byte};
  assign fetch_ok = fetch_req && state != LOAD;
  assign aligned  = fetch_addr[1:0] == 2'b00;
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wword;
`ifdef IMEM_PARITY_EN
  logic par [DEPTH];
  always_ff @(posedge clk)
    if (wr) par[wptr] <= ^wword;
  assign perr_next = fetch_ok && aligned && ((^mem[raddr]) != par[raddr]);
`else
  assign perr_next = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      fetch_valid    <= 1'b0;
      fetch_data     <= '0;
      fetch_misalign <= 1'b0;
      fetch_perr     <= 1'b0;
      ld_ready       <= 1'b0;
      ld_busy        <= 1'b0;
      ld_done        <= 1'b0;
      ld_count       <= '0;
      wptr           <= '0;
      len            <= '0;
      byte_idx       <= '0;
      asm_q          <= '0;
    end else begin
      fetch_valid    <= fetch_ok;
      fetch_data     <= (fetch_ok && aligned) ? mem[raddr] : '0;
      fetch_misalign <= fetch_ok && !aligned;
      fetch_perr     <= perr_next;
      ld_done        <= 1'b0;
      case (state)
        IDLE: if (ld_start) begin
          ld_count <= '0;
          byte_idx <= '0;
          wptr     <= ld_base;
          len      <= ld_len;
          state    <= (ld_len != '0) ? LOAD : DONE;
          ld_ready <= ld_len != '0;
          ld_busy  <= ld_len != '0;
          ld_done  <= ld_len == '0;
        end
        LOAD: if (take) begin
          // first three bytes shift in; the fourth completes the word on this edge
          asm_q    <= {asm_q[15:0], ld_byte};
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            wptr     <= wptr + 1'b1;
            ld_count <= ld_count + 1'b1;
            if ((ld_count + 1'b1) == len) begin
              state    <= DONE;
              ld_ready <= 1'b0;
              ld_busy  <= 1'b0;
              ld_done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_memory_loadable.sv
// tb_instruction_memory_loadable: directed checks of fetch, load, wrap, blocking, reset and parity.
module tb_instruction_memory_loadable;
  logic        clk, rst;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic        fetch_valid, fetch_misalign, fetch_perr;
  logic [31:0] fetch_data;
  logic        ld_start, ld_byte_valid;
  logic [7:0]  ld_base, ld_byte;
  logic [8:0]  ld_len, ld_count;
  logic        ld_ready, ld_busy, ld_done;
  int total = 0;
  int bad = 0;
  instruction_memory_loadable #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_misalign(fetch_misalign), .fetch_perr(fetch_perr),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_count(ld_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      ld_byte_valid = 1'b1;
      ld_byte = w[8*i +: 8];
      tick();
    end
    ld_byte_valid = 1'b0;
  endtask
  task automatic start(input logic [7:0] base, input logic [8:0] len);
    ld_start = 1'b1;
    ld_base = base;
    ld_len = len;
    tick();
    ld_start = 1'b0;
  endtask
  task automatic fetch(input logic [9:0] a);
    fetch_req = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    fetch_req = 0; fetch_addr = 0; ld_start = 0; ld_base = 0; ld_len = 0;
    ld_byte_valid = 0; ld_byte = 0;
    #3;
    chk("rst_async_busy", {31'd0, ld_busy}, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, fetch_valid}, 0);
    chk("rst_data", fetch_data, 0);
    chk("rst_misalign", {31'd0, fetch_misalign}, 0);
    chk("rst_perr", {31'd0, fetch_perr}, 0);
    chk("rst_ready", {31'd0, ld_ready}, 0);
    chk("rst_done", {31'd0, ld_done}, 0);
    chk("rst_count", {23'd0, ld_count}, 0);
    // basic load of two words then fetch them back
    start(8'd0, 9'd2);
    chk("ld_busy", {31'd0, ld_busy}, 1);
    chk("ld_ready", {31'd0, ld_ready}, 1);
    send_word(32'h20100007);
    chk("ld_mid_done", {31'd0, ld_done}, 0);
    send_word(32'h00008820);
    chk("ld_done", {31'd0, ld_done}, 1);
    chk("ld_count2", {23'd0, ld_count}, 2);
    chk("ld_busy_off", {31'd0, ld_busy}, 0);
    tick();
    chk("ld_done_pulse", {31'd0, ld_done}, 0);
    fetch(10'h000);
    chk("f0_valid", {31'd0, fetch_valid}, 1);
    chk("f0_data", fetch_data, 32'h20100007);
    chk("f0_misalign", {31'd0, fetch_misalign}, 0);
    tick();
    chk("f_idle_valid", {31'd0, fetch_valid}, 0);
    fetch(10'h004);
    chk("f4_data", fetch_data, 32'h00008820);
    chk("count_hold", {23'd0, ld_count}, 2);
    // wrap from the last word back to word 0
    start(8'd255, 9'd2);
    send_word(32'hAAAAAAAA);
    send_word(32'h55555555);
    chk("wrap_done", {31'd0, ld_done}, 1);
    fetch(10'h3FC);
    chk("wrap_255", fetch_data, 32'hAAAAAAAA);
    fetch(10'h000);
    chk("wrap_0", fetch_data, 32'h55555555);
    // fetch blocked during load; stray bytes while idle are dropped
    ld_byte_valid = 1'b1; ld_byte = 8'hFF;
    tick();
    ld_byte_valid = 1'b0;
    start(8'd10, 9'd1);
    fetch_req = 1'b1; fetch_addr = 10'h000;
    ld_byte_valid = 1'b1; ld_byte = 8'h11;
    tick();
    fetch_req = 1'b0; ld_byte_valid = 1'b0;
    chk("blocked_valid", {31'd0, fetch_valid}, 0);
    send_word(32'h22334455);
    chk("blk_count", {23'd0, ld_count}, 1);
    fetch(10'h028);
    chk("blk_word", fetch_data, 32'h11223344);
    fetch(10'h006);
    chk("mis_valid", {31'd0, fetch_valid}, 1);
    chk("mis_data", fetch_data, 0);
    chk("mis_flag", {31'd0, fetch_misalign}, 1);
    chk("mis_perr", {31'd0, fetch_perr}, 0);
    // simultaneous start and fetch: fetch sees pre-load contents
    fetch_req = 1'b1; fetch_addr = 10'h004;
    start(8'd1, 9'd1);
    fetch_req = 1'b0;
    chk("sim_valid", {31'd0, fetch_valid}, 1);
    chk("sim_old", fetch_data, 32'h00008820);
    chk("sim_busy", {31'd0, ld_busy}, 1);
    send_word(32'hDEADBEEF);
    fetch(10'h004);
    chk("sim_new", fetch_data, 32'hDEADBEEF);
    // asynchronous reset in the middle of the second word
    start(8'd0, 9'd2);
    send_word(32'h01020304);
    ld_byte_valid = 1'b1; ld_byte = 8'hAA; tick();
    ld_byte = 8'hBB; tick();
    ld_byte_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, ld_busy}, 0);
    chk("mid_rst_ready", {31'd0, ld_ready}, 0);
    tick();
    rst = 1'b0;
    fetch(10'h000);
    chk("mid_rst_w0", fetch_data, 32'h01020304);
    fetch(10'h004);
    chk("mid_rst_w1", fetch_data, 32'hDEADBEEF);
    // zero-length load finishes immediately without writing
    start(8'd0, 9'd0);
    chk("len0_done", {31'd0, ld_done}, 1);
    chk("len0_busy", {31'd0, ld_busy}, 0);
    chk("len0_count", {23'd0, ld_count}, 0);
    tick();
    chk("len0_pulse", {31'd0, ld_done}, 0);
    fetch(10'h000);
    chk("len0_nowrite", fetch_data, 32'h01020304);
    // parity
    start(8'd20, 9'd1);
    send_word(32'h12345678);
    fetch(10'h050);
    chk("par_clean", {31'd0, fetch_perr}, 0);
    chk("par_data", fetch_data, 32'h12345678);
`ifdef IMEM_PARITY_EN
    dut.mem[20] = 32'h12345679;
    fetch(10'h050);
    chk("par_err", {31'd0, fetch_perr}, 1);
    chk("par_err_data", fetch_data, 32'h12345679);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
